// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the RAM arbiter.
//   rd_owner_t : which port (if any) a pending RAM read belongs to
//   STARVE_W   : width of the DMA starvation counter
package mem_arb_pkg;

    localparam int STARVE_W = 4;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        CPU  = 2'd1,
        DMA  = 2'd2
    } rd_owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between the CPU and a
// DMA requester. At most one access is issued per clock. The CPU has fixed
// priority; a starvation counter forces a DMA win after STARVE_MAX blocked
// cycles unless the CPU holds cpu_lock.
//
// Ports
//   clk, rst                     : clock, synchronous active-high reset
//   cpu_req/we/addr/wdata/lock   : CPU request side
//   cpu_ack, cpu_rvalid, cpu_rdata : CPU response side
//   dma_req/we/addr/wdata        : DMA request side
//   dma_ack, dma_rvalid, dma_rdata : DMA response side
//   ram_en/we/addr/wdata, ram_rdata : RAM port (1-cycle read latency)
//   dbg_starve, dbg_rd_owner     : internal state, for observation only
//
// Handshake: a requester holds req/we/addr/wdata stable until it sees ack in
// the same cycle; ack means the access was issued to the RAM that cycle.
// A new request may be presented the cycle after ack. For reads, rvalid is a
// one-cycle pulse the cycle after ack; rdata is only meaningful with rvalid.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 15,
    parameter int DW         = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [AW-1:0]       cpu_addr,
    input  logic [DW-1:0]       cpu_wdata,
    input  logic                cpu_lock,
    output logic                cpu_ack,
    output logic                cpu_rvalid,
    output logic [DW-1:0]       cpu_rdata,

    input  logic                dma_req,
    input  logic                dma_we,
    input  logic [AW-1:0]       dma_addr,
    input  logic [DW-1:0]       dma_wdata,
    output logic                dma_ack,
    output logic                dma_rvalid,
    output logic [DW-1:0]       dma_rdata,

    output logic                ram_en,
    output logic                ram_we,
    output logic [AW-1:0]       ram_addr,
    output logic [DW-1:0]       ram_wdata,
    input  logic [DW-1:0]       ram_rdata,

    output logic [STARVE_W-1:0] dbg_starve,
    output logic [1:0]          dbg_rd_owner
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve_q, starve_d;
    rd_owner_t           rd_owner_q, rd_owner_d;

    logic force_dma;
    logic grant_cpu;
    logic grant_dma;

    always_comb begin
        force_dma  = 1'b0;
        grant_cpu  = 1'b0;
        grant_dma  = 1'b0;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        starve_d   = starve_q;
        rd_owner_d = NONE;

        // cpu_lock only masks the override; the counter keeps saturating so
        // DMA wins the first cycle after the lock drops.
        force_dma = dma_req && (starve_q == STARVE_LIM) && !cpu_lock;

        // Grants are suppressed during reset regardless of requests.
        if (!rst) begin
            if (force_dma || (dma_req && !cpu_req)) begin
                grant_dma = 1'b1;
            end else if (cpu_req) begin
                grant_cpu = 1'b1;
            end
        end

        if (grant_dma) begin
            ram_en    = 1'b1;
            ram_we    = dma_we;
            ram_addr  = dma_addr;
            ram_wdata = dma_wdata;
        end else if (grant_cpu) begin
            ram_en    = 1'b1;
            ram_we    = cpu_we;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
        end

        if (!dma_req || grant_dma) begin
            starve_d = '0;
        end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + STARVE_W'(1);
        end

        if (grant_cpu && !cpu_we) begin
            rd_owner_d = CPU;
        end else if (grant_dma && !dma_we) begin
            rd_owner_d = DMA;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q   <= '0;
            rd_owner_q <= NONE;
        end else begin
            starve_q   <= starve_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign cpu_ack = grant_cpu;
    assign dma_ack = grant_dma;

    // Gating with rst drops a read whose return cycle coincides with reset.
    assign cpu_rvalid = (rd_owner_q == CPU) && !rst;
    assign dma_rvalid = (rd_owner_q == DMA) && !rst;

    assign cpu_rdata = ram_rdata;
    assign dma_rdata = ram_rdata;

    assign dbg_starve   = starve_q;
    assign dbg_rd_owner = rd_owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int AW = 15;
  localparam int DW = 8;
  localparam int STARVE_MAX = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic          cpu_req, cpu_we, cpu_lock;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          dma_req, dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_ack, dma_rvalid;
  logic [DW-1:0] dma_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [3:0]    dbg_starve;
  logic [1:0]    dbg_rd_owner;

  mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_lock(cpu_lock), .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .dbg_starve(dbg_starve), .dbg_rd_owner(dbg_rd_owner)
  );

  // Behavioural 1-cycle synchronous RAM.
  logic [DW-1:0] ram_mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram_mem[ram_addr];
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  // The model counts how many consecutive cycles DMA has asked without being
  // served, and keeps its own copy of memory fed by the accesses it expects
  // to be granted. Expected read returns go through exp_q.
  logic          mon_en = 1'b0;
  int            m_wait = 0;
  logic [DW-1:0] model_mem [0:(1<<AW)-1];
  logic [DW:0]   exp_q [$];   // {is_dma, data}
  logic          m_dack, m_cack, m_have, m_crv, m_drv, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd;
  logic [DW:0]   m_ent;
  int            m_starve;

  always @(negedge clk) begin
    if (mon_en) begin
      m_dack = !rst && dma_req && (!cpu_req || (m_wait >= STARVE_MAX && !cpu_lock));
      m_cack = !rst && cpu_req && !m_dack;
      m_we   = m_dack ? dma_we : (m_cack ? cpu_we : 1'b0);
      m_addr = m_dack ? dma_addr : (m_cack ? cpu_addr : '0);
      m_wd   = m_dack ? dma_wdata : (m_cack ? cpu_wdata : '0);
      m_have = exp_q.size() > 0;
      m_ent  = '0;
      if (m_have) m_ent = exp_q.pop_front();
      m_crv = !rst && m_have && !m_ent[DW];
      m_drv = !rst && m_have && m_ent[DW];
      m_starve = (m_wait > STARVE_MAX) ? STARVE_MAX : m_wait;

      chk("cpu_ack", cpu_ack, m_cack);
      chk("dma_ack", dma_ack, m_dack);
      chk("ram_en", ram_en, m_dack || m_cack);
      chk("ram_we", ram_we, m_we);
      chk("ram_addr", ram_addr, m_addr);
      chk("ram_wdata", ram_wdata, m_wd);
      chk("cpu_rvalid", cpu_rvalid, m_crv);
      chk("dma_rvalid", dma_rvalid, m_drv);
      chk("both_rvalid", cpu_rvalid && dma_rvalid, 1'b0);
      chk("starve", dbg_starve, m_starve);
      if (m_crv) chk("cpu_rdata", cpu_rdata, m_ent[DW-1:0]);
      if (m_drv) chk("dma_rdata", dma_rdata, m_ent[DW-1:0]);

      if (rst) begin
        m_wait = 0;
      end else begin
        m_wait = (dma_req && !m_dack) ? m_wait + 1 : 0;
        if (m_cack) begin
          if (cpu_we) model_mem[cpu_addr] = cpu_wdata;
          else        exp_q.push_back({1'b0, model_mem[cpu_addr]});
        end
        if (m_dack) begin
          if (dma_we) model_mem[dma_addr] = dma_wdata;
          else        exp_q.push_back({1'b1, model_mem[dma_addr]});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd);
    cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
  endtask

  task automatic set_dma(input logic req, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd);
    dma_req = req; dma_we = we; dma_addr = addr; dma_wdata = wd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  logic [AW-1:0] pre_addr [3];
  logic [DW-1:0] pre_data [3];
  int            ack_cycle;
  logic          found;

  initial begin
    pre_addr[0] = 15'h7FFF; pre_data[0] = 8'hC3;
    pre_addr[1] = 15'h0A00; pre_data[1] = 8'h11;
    pre_addr[2] = 15'h0B00; pre_data[2] = 8'h22;

    rst = 1'b1;
    cpu_lock = 1'b0;
    set_cpu(1'b1, 1'b0, 15'h0123, 8'h00);
    set_dma(1'b1, 1'b0, 15'h0456, 8'h00);
    mon_en = 1'b1;

    // Reset with both requests asserted: nothing issued.
    repeat (3) begin
      @(negedge clk);
      chk("rst_ram_en", ram_en, 1'b0);
      chk("rst_cpu_ack", cpu_ack, 1'b0);
      chk("rst_dma_ack", dma_ack, 1'b0);
      chk("rst_rvalid", cpu_rvalid | dma_rvalid, 1'b0);
      chk("rst_starve", dbg_starve, 4'd0);
      next_cycle();
    end
    rst = 1'b0;
    set_cpu(1'b0, 1'b0, '0, '0);
    set_dma(1'b0, 1'b0, '0, '0);
    next_cycle();

    // CPU only: write then read back.
    set_cpu(1'b1, 1'b1, 15'h0123, 8'h5A);
    @(negedge clk);
    chk("t1_wr_ack", cpu_ack, 1'b1);
    chk("t1_wr_dma_ack", dma_ack, 1'b0);
    next_cycle();
    set_cpu(1'b1, 1'b0, 15'h0123, 8'h00);
    @(negedge clk);
    chk("t1_rd_ack", cpu_ack, 1'b1);
    chk("t1_no_rvalid_after_write", cpu_rvalid, 1'b0);
    next_cycle();
    set_cpu(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("t1_rvalid", cpu_rvalid, 1'b1);
    chk("t1_rdata", cpu_rdata, 8'h5A);
    chk("t1_dma_rvalid", dma_rvalid, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("t1_rvalid_pulse", cpu_rvalid, 1'b0);
    next_cycle();

    // Preload test data through the CPU port.
    for (int i = 0; i < 3; i++) begin
      set_cpu(1'b1, 1'b1, pre_addr[i], pre_data[i]);
      @(negedge clk);
      chk("pre_ack", cpu_ack, 1'b1);
      next_cycle();
    end
    set_cpu(1'b0, 1'b0, '0, '0);
    next_cycle();

    // Contention: CPU writes every cycle, DMA reads 0x7FFF.
    set_dma(1'b1, 1'b0, 15'h7FFF, 8'h00);
    ack_cycle = 0;
    found = 1'b0;
    for (int c = 1; c <= 8 && !found; c++) begin
      set_cpu(1'b1, 1'b1, 15'h0200 + AW'(c), DW'(c));
      @(negedge clk);
      if (dma_ack) begin
        found = 1'b1;
        ack_cycle = c;
        chk("t2_cpu_blocked", cpu_ack, 1'b0);
      end
      next_cycle();
    end
    chk("t2_dma_ack_cycle", ack_cycle, 5);
    set_dma(1'b0, 1'b0, '0, '0);
    set_cpu(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("t2_dma_rvalid", dma_rvalid, 1'b1);
    chk("t2_dma_rdata", dma_rdata, 8'hC3);
    chk("t2_starve_clr", dbg_starve, 4'd0);
    next_cycle();

    // cpu_lock held 10 cycles under contention; DMA write waits.
    cpu_lock = 1'b1;
    set_dma(1'b1, 1'b1, 15'h0400, 8'h99);
    for (int c = 1; c <= 10; c++) begin
      set_cpu(1'b1, 1'b1, 15'h0300 + AW'(c), DW'(c + 16));
      @(negedge clk);
      chk("t3_no_dma_ack", dma_ack, 1'b0);
      if (c >= 5) chk("t3_starve_hold", dbg_starve, 4'd4);
      next_cycle();
    end
    cpu_lock = 1'b0;
    @(negedge clk);
    chk("t3_dma_after_lock", dma_ack, 1'b1);
    chk("t3_cpu_blocked", cpu_ack, 1'b0);
    next_cycle();
    set_dma(1'b0, 1'b0, '0, '0);
    set_cpu(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("t3_starve_clr", dbg_starve, 4'd0);
    chk("t3_no_rvalid_write", dma_rvalid, 1'b0);
    next_cycle();

    // Read back the DMA write to prove it landed.
    set_cpu(1'b1, 1'b0, 15'h0400, 8'h00);
    next_cycle();
    set_cpu(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("t3_readback", cpu_rdata, 8'h99);
    next_cycle();

    // Interleaved: CPU read A then DMA read B.
    set_cpu(1'b1, 1'b0, 15'h0A00, 8'h00);
    @(negedge clk);
    chk("t4_cpu_ack", cpu_ack, 1'b1);
    next_cycle();
    set_cpu(1'b0, 1'b0, '0, '0);
    set_dma(1'b1, 1'b0, 15'h0B00, 8'h00);
    @(negedge clk);
    chk("t4_dma_ack", dma_ack, 1'b1);
    chk("t4_cpu_rvalid", cpu_rvalid, 1'b1);
    chk("t4_cpu_rdata", cpu_rdata, 8'h11);
    chk("t4_dma_rvalid_early", dma_rvalid, 1'b0);
    next_cycle();
    set_dma(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("t4_dma_rvalid", dma_rvalid, 1'b1);
    chk("t4_dma_rdata", dma_rdata, 8'h22);
    chk("t4_cpu_rvalid_clr", cpu_rvalid, 1'b0);
    next_cycle();

    // Reset pulsed the cycle after a CPU read ack.
    set_cpu(1'b1, 1'b0, 15'h0123, 8'h00);
    @(negedge clk);
    chk("t5_rd_ack", cpu_ack, 1'b1);
    next_cycle();
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("t5_rvalid_supp", cpu_rvalid, 1'b0);
      chk("t5_ram_en", ram_en, 1'b0);
      chk("t5_cpu_ack", cpu_ack, 1'b0);
      next_cycle();
    end
    rst = 1'b0;
    @(negedge clk);
    chk("t5_resume_ack", cpu_ack, 1'b1);
    chk("t5_rvalid_still0", cpu_rvalid, 1'b0);
    next_cycle();
    set_cpu(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("t5_reissue_rvalid", cpu_rvalid, 1'b1);
    chk("t5_reissue_rdata", cpu_rdata, 8'h5A);
    next_cycle();

    // Idle for 20 cycles.
    repeat (20) begin
      @(negedge clk);
      chk("t6_ram_en", ram_en, 1'b0);
      chk("t6_starve", dbg_starve, 4'd0);
      chk("t6_acks", cpu_ack | dma_ack | cpu_rvalid | dma_rvalid, 1'b0);
      next_cycle();
    end

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
